game_state_ctrl: RTL

- Owns the game-level `state` bus for the grid chase game. `ghost_move` consumes this bus and only advances while it reads 2'b00.
- Tracks the player position from button edges and compares it against the ghost position every cycle.
- Manages lives, goal detection, pause, and restart, and drives PLAY/PAUSE/LOSE/WIN back to the ghost logic and the display.

---
 rtl/game_state_ctrl_if.sv | 26 ++
 rtl/game_state_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl_if.sv
// Bundle of button, ghost and game-status signals shared between the
// game-state controller (slave side) and whatever drives/observes it.
interface game_state_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_pause;
    logic [2:0] ghost_x;
    logic [2:0] ghost_y;
    logic [1:0] state;
    logic [2:0] player_x;
    logic [2:0] player_y;
    logic [1:0] lives;
    logic [7:0] step_cnt;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_pause, ghost_x, ghost_y,
        input  state, player_x, player_y, lives, step_cnt
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_pause, ghost_x, ghost_y,
        output state, player_x, player_y, lives, step_cnt
    );
endinterface

// File: rtl/game_state_ctrl.sv
// Game-level state owner for the grid chase game: player movement, lives,
// goal, pause and restart. The state bus gates the ghost logic (moves only in PLAY).
//
//   state | meaning
//   PLAY  | player moves, collision and goal are evaluated
//   PAUSE | everything frozen except a pause press returning to PLAY
//   LOSE  | out of lives; pause press restarts
//   WIN   | goal reached; pause press restarts
module game_state_ctrl #(
    parameter int X_MAX      = 5,
    parameter int Y_MAX      = 5,
    parameter int START_X    = 0,
    parameter int START_Y    = 0,
    parameter int GOAL_X     = 5,
    parameter int GOAL_Y     = 0,
    parameter int LIVES_INIT = 3
) (
    input logic               g_clk,
    input logic               reset,
    game_state_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'b00,
        ST_PAUSE = 2'b01,
        ST_LOSE  = 2'b10,
        ST_WIN   = 2'b11
    } state_t;

    localparam logic [2:0] XM    = 3'(X_MAX);
    localparam logic [2:0] YM    = 3'(Y_MAX);
    localparam logic [2:0] SX    = 3'(START_X);
    localparam logic [2:0] SY    = 3'(START_Y);
    localparam logic [2:0] GX    = 3'(GOAL_X);
    localparam logic [2:0] GY    = 3'(GOAL_Y);
    localparam logic [1:0] LINIT = 2'(LIVES_INIT);

    // bit order: {pause, right, left, down, up}
    logic [4:0] btn;
    logic [4:0] prev;
    logic [4:0] ev;

    state_t     state_q;
    logic [2:0] px;
    logic [2:0] py;
    logic [1:0] lives_q;
    logic [7:0] steps_q;

    logic       hit;
    logic       at_goal;
    logic       move_ok;
    logic [2:0] nx;
    logic [2:0] ny;

    assign btn     = {bus.btn_pause, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
    assign ev      = btn & ~prev;
    assign hit     = (px == bus.ghost_x) && (py == bus.ghost_y);
    assign at_goal = (px == GX) && (py == GY);

    // Only the highest-priority event is considered; if it hits a wall, nothing moves.
    always_comb begin
        nx      = px;
        ny      = py;
        move_ok = 1'b0;
        if (ev[0]) begin
            if (py < YM) begin
                ny      = py + 3'd1;
                move_ok = 1'b1;
            end
        end else if (ev[1]) begin
            if (py != 3'd0) begin
                ny      = py - 3'd1;
                move_ok = 1'b1;
            end
        end else if (ev[2]) begin
            if (px != 3'd0) begin
                nx      = px - 3'd1;
                move_ok = 1'b1;
            end
        end else if (ev[3]) begin
            if (px < XM) begin
                nx      = px + 3'd1;
                move_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge g_clk or negedge reset) begin
        if (!reset) begin
            prev    <= '0;
            state_q <= ST_PLAY;
            px      <= SX;
            py      <= SY;
            lives_q <= LINIT;
            steps_q <= '0;
        end else begin
            prev <= btn;
            case (state_q)
                ST_PLAY: begin
                    if (ev[4]) begin
                        state_q <= ST_PAUSE;
                    end else if (hit) begin
                        if (lives_q > 2'd1) begin
                            lives_q <= lives_q - 2'd1;
                            px      <= SX;
                            py      <= SY;
                        end else begin
                            lives_q <= 2'd0;
                            state_q <= ST_LOSE;
                        end
                    end else begin
                        if (at_goal) begin
                            state_q <= ST_WIN;
                        end
                        if (move_ok) begin
                            px <= nx;
                            py <= ny;
                            if (steps_q != 8'hFF) begin
                                steps_q <= steps_q + 8'd1;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (ev[4]) begin
                        state_q <= ST_PLAY;
                    end
                end
                default: begin
                    // LOSE / WIN: restart keeps the button history intact
                    if (ev[4]) begin
                        state_q <= ST_PLAY;
                        px      <= SX;
                        py      <= SY;
                        lives_q <= LINIT;
                        steps_q <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.state    = state_q;
    assign bus.player_x = px;
    assign bus.player_y = py;
    assign bus.lives    = lives_q;
    assign bus.step_cnt = steps_q;

endmodule
